// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard detection over a DEPTH-stage in-flight destination tracker.
// Optional FWD_STATS_EN adds saturating stall_count / fwd_count outputs.
module fwd_hazard_unit #(
    parameter int REG_W      = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    id_valid,
    input  logic [NSRC*REG_W-1:0]   id_src,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_wen,
    input  logic                    id_load,
    input  logic                    freeze,
    input  logic                    flush,
    output logic                    hazard_stall,
    output logic [NSRC*SEL_W-1:0]   fwd_sel,
    output logic [DEPTH-1:0]        stage_valid
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]             stall_count,
    output logic [31:0]             fwd_count
`endif
);

    logic             st_vld  [1:DEPTH];
    logic [REG_W-1:0] st_rd   [1:DEPTH];
    logic             st_wen  [1:DEPTH];
    logic             st_load [1:DEPTH];

    logic [SEL_W-1:0] op_sel  [NSRC];
    logic             op_ld   [NSRC];

    // ID stage: youngest matching producer wins, so scan oldest to youngest and let later hits override
    always_comb begin
        fwd_sel      = '0;
        hazard_stall = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            op_sel[k] = '0;
            op_ld[k]  = 1'b0;
            for (int s = DEPTH; s >= 1; s--) begin
                if (st_vld[s] && st_wen[s] && st_rd[s] != '0 &&
                    st_rd[s] == id_src[k*REG_W +: REG_W]) begin
                    op_sel[k] = SEL_W'(s);
                    op_ld[k]  = st_load[s];
                end
            end
            fwd_sel[k*SEL_W +: SEL_W] = op_sel[k];
            if (id_valid && op_ld[k] && op_sel[k] != '0 && int'(op_sel[k]) < LOAD_READY)
                hazard_stall = 1'b1;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int s = 1; s <= DEPTH; s++)
            stage_valid[s-1] = st_vld[s] & st_wen[s];
    end

    // Tracked stages: valid flags carry reset, the rest simply follow the shift
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 1; s <= DEPTH; s++)
                st_vld[s] <= 1'b0;
        end else if (!freeze) begin
            for (int s = DEPTH; s >= 2; s--)
                st_vld[s] <= st_vld[s-1];
            st_vld[1] <= id_valid && !flush && !hazard_stall;
        end
    end

    always_ff @(posedge CLK) begin
        if (!freeze) begin
            for (int s = DEPTH; s >= 2; s--) begin
                st_rd[s]   <= st_rd[s-1];
                st_wen[s]  <= st_wen[s-1];
                st_load[s] <= st_load[s-1];
            end
            st_rd[1]   <= id_rd;
            st_wen[1]  <= id_wen;
            st_load[1] <= id_load;
        end
    end

`ifdef FWD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else if (!freeze) begin
            if (hazard_stall)
                stall_count <= sat_inc(stall_count);
            else if (id_valid && |fwd_sel)
                fwd_count <= sat_inc(fwd_count);
        end
    end
`endif

endmodule
